// File: rtl/code_seq_lock.sv
// Code-sequence lock: matches a stream of codes against a programmable reference
// sequence, with inter-code timeout, consecutive-failure counting and timed lockout.
//
// state | meaning
// IDLE  | waiting for the first code, reference table writable
// MATCH | partway through an attempt, inter-code timer running
// GRANT | one-cycle accept pulse
// FAIL  | one-cycle reject pulse, failure count bumped
// LOCK  | lockout, all codes ignored until the lock timer expires
module code_seq_lock #(
    parameter int CODE_W   = 8,
    parameter int SEQ_LEN  = 4,
    parameter int MAX_FAIL = 3,
    parameter int TIMEOUT  = 255,
    parameter int LOCK_CYC = 1023,
    localparam int AW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int PW      = $clog2(SEQ_LEN + 1)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              valid,
    input  logic [CODE_W-1:0] entrada,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [CODE_W-1:0] prog_data,
    output logic [3:0]        saida,
    output logic              grant,
    output logic              fail,
    output logic              locked,
    output logic [3:0]        fail_cnt,
    output logic [PW-1:0]     pos
);

    localparam logic [3:0] S_IDLE  = 4'b0000;
    localparam logic [3:0] S_MATCH = 4'b0001;
    localparam logic [3:0] S_GRANT = 4'b1001;
    localparam logic [3:0] S_FAIL  = 4'b1000;
    localparam logic [3:0] S_LOCK  = 4'b1010;

    // One down-counter serves both the inter-code timeout and the lockout.
    localparam int TMAX = (TIMEOUT > LOCK_CYC) ? TIMEOUT : LOCK_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYC - 1);
    localparam logic [PW-1:0] SEQ_END   = PW'(SEQ_LEN);
    localparam logic [AW:0]   ADDR_LIM  = (AW + 1)'(SEQ_LEN);
    localparam logic [3:0]    FAIL_LIM  = 4'(MAX_FAIL);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [PW-1:0]     pos_nxt;
    logic [PW-1:0]     pos_inc;
    logic [3:0]        fcnt_nxt;
    logic [3:0]        fcnt_inc;
    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_nxt;
    logic [CODE_W-1:0] cur_ref;
    logic              wr_ok;
    logic [CODE_W-1:0] ref_mem [SEQ_LEN];

    assign saida    = state;
    assign pos_inc  = pos + PW'(1);
    assign fcnt_inc = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
    assign cur_ref  = ref_mem[pos[AW-1:0]];
    assign wr_ok    = prog_we && (state == S_IDLE) && ({1'b0, prog_addr} < ADDR_LIM);

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        fcnt_nxt  = fail_cnt;
        tmr_nxt   = tmr;
        case (state)
            S_IDLE, S_MATCH: begin
                if (valid) begin
                    if (entrada == cur_ref) begin
                        if (pos_inc == SEQ_END) begin
                            state_nxt = S_GRANT;
                            pos_nxt   = '0;
                            fcnt_nxt  = '0;
                            tmr_nxt   = '0;
                        end else begin
                            state_nxt = S_MATCH;
                            pos_nxt   = pos_inc;
                            tmr_nxt   = TO_LOAD;
                        end
                    end else begin
                        state_nxt = S_FAIL;
                        pos_nxt   = '0;
                        fcnt_nxt  = fcnt_inc;
                        tmr_nxt   = '0;
                    end
                end else if (state == S_MATCH) begin
                    if (tmr == '0) begin
                        state_nxt = S_FAIL;
                        pos_nxt   = '0;
                        fcnt_nxt  = fcnt_inc;
                    end else begin
                        tmr_nxt = tmr - TW'(1);
                    end
                end
            end
            S_GRANT: state_nxt = S_IDLE;
            S_FAIL: begin
                if (fail_cnt >= FAIL_LIM) begin
                    state_nxt = S_LOCK;
                    tmr_nxt   = LOCK_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOCK: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                    fcnt_nxt  = '0;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pos_nxt   = '0;
                tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= S_IDLE;
            pos      <= '0;
            fail_cnt <= '0;
            tmr      <= '0;
            grant    <= 1'b0;
            fail     <= 1'b0;
            locked   <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) ref_mem[i] <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            fail_cnt <= fcnt_nxt;
            tmr      <= tmr_nxt;
            grant    <= (state_nxt == S_GRANT);
            fail     <= (state_nxt == S_FAIL);
            locked   <= (state_nxt == S_LOCK);
            // Compare above used the old entry; the write lands for the next cycle.
            if (wr_ok) ref_mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_code_seq_lock.sv
// Directed bench for code_seq_lock: grant, reject, lockout, timeout, reset and
// programming scenarios with hand-computed expected outputs.
module tb_code_seq_lock;

    localparam int IDLE  = 0;
    localparam int MATCH = 1;
    localparam int GRANT = 9;
    localparam int FAILS = 8;
    localparam int LOCK  = 10;

    logic       clk = 1'b0;
    logic       res;
    logic       valid;
    logic [7:0] entrada;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] saida;
    logic       grant;
    logic       fail;
    logic       locked;
    logic [3:0] fail_cnt;
    logic [2:0] pos;

    int total = 0;
    int bad   = 0;
    logic [7:0] seq [4] = '{8'h90, 8'hA4, 8'h82, 8'hC7};

    code_seq_lock #(
        .CODE_W(8), .SEQ_LEN(4), .MAX_FAIL(3), .TIMEOUT(255), .LOCK_CYC(1023)
    ) dut (
        .clk(clk), .res(res), .valid(valid), .entrada(entrada),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .saida(saida), .grant(grant), .fail(fail), .locked(locked),
        .fail_cnt(fail_cnt), .pos(pos)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {saida, grant, fail, locked, fail_cnt, pos};
    endfunction

    function automatic logic [13:0] ev(int s, int g, int f, int l, int fc, int p);
        return {s[3:0], g[0], f[0], l[0], fc[3:0], p[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        valid = 1'b1;
        entrada = c;
        tick();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic prog(input logic [1:0] a, input logic [7:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; valid = 1'b0; entrada = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        idle(2);
        res = 1'b0;
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL reset got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
        idle(5);
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
    endtask

    task automatic test_seq_grant();
        for (int i = 0; i < 4; i++) prog(2'(i), seq[i]);
        send(8'h90);
        total++; if (obs() !== ev(MATCH,0,0,0,0,1)) begin bad++; $display("FAIL grant_p1 got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,1)); end
        idle(3);
        send(8'hA4);
        total++; if (obs() !== ev(MATCH,0,0,0,0,2)) begin bad++; $display("FAIL grant_p2 got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,2)); end
        idle(3);
        send(8'h82);
        total++; if (obs() !== ev(MATCH,0,0,0,0,3)) begin bad++; $display("FAIL grant_p3 got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,3)); end
        idle(3);
        send(8'hC7);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL grant_pulse got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL grant_after got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(seq[i]);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL b2b_grant got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        send(8'h90);
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL b2b_ignored got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
        send(8'h90);
        total++; if (obs() !== ev(MATCH,0,0,0,0,1)) begin bad++; $display("FAIL b2b_restart got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,1)); end
        for (int i = 1; i < 4; i++) send(seq[i]);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL b2b_grant2 got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
    endtask

    task automatic test_wrong_code();
        send(8'h90); send(8'hA4); send(8'hBA);
        total++; if (obs() !== ev(FAILS,0,1,0,1,0)) begin bad++; $display("FAIL wrong_fail got=%h exp=%h", obs(), ev(FAILS,0,1,0,1,0)); end
        tick();
        total++; if (obs() !== ev(IDLE,0,0,0,1,0)) begin bad++; $display("FAIL wrong_idle got=%h exp=%h", obs(), ev(IDLE,0,0,0,1,0)); end
        for (int i = 0; i < 4; i++) send(seq[i]);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL wrong_clear got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
    endtask

    task automatic test_lockout();
        int n;
        int g;
        send(8'h00);
        total++; if (obs() !== ev(FAILS,0,1,0,1,0)) begin bad++; $display("FAIL lock_f1 got=%h exp=%h", obs(), ev(FAILS,0,1,0,1,0)); end
        tick();
        send(8'h00);
        total++; if (obs() !== ev(FAILS,0,1,0,2,0)) begin bad++; $display("FAIL lock_f2 got=%h exp=%h", obs(), ev(FAILS,0,1,0,2,0)); end
        tick();
        send(8'h00);
        total++; if (obs() !== ev(FAILS,0,1,0,3,0)) begin bad++; $display("FAIL lock_f3 got=%h exp=%h", obs(), ev(FAILS,0,1,0,3,0)); end
        tick();
        total++; if (obs() !== ev(LOCK,0,0,1,3,0)) begin bad++; $display("FAIL lock_enter got=%h exp=%h", obs(), ev(LOCK,0,0,1,3,0)); end
        n = 1;
        g = 0;
        for (int i = 0; i < 2000 && locked; i++) begin
            valid = 1'b1;
            entrada = seq[i % 4];
            tick();
            if (grant || fail) g++;
            if (locked) n++;
        end
        valid = 1'b0;
        total++; if (n !== 1023) begin bad++; $display("FAIL lock_len got=%0d exp=%0d", n, 1023); end
        total++; if (g !== 0) begin bad++; $display("FAIL lock_pulses got=%0d exp=%0d", g, 0); end
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL lock_exit got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
    endtask

    task automatic test_timeout();
        send(8'h90);
        idle(254);
        total++; if (obs() !== ev(MATCH,0,0,0,0,1)) begin bad++; $display("FAIL to_before got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,1)); end
        tick();
        total++; if (obs() !== ev(FAILS,0,1,0,1,0)) begin bad++; $display("FAIL to_fire got=%h exp=%h", obs(), ev(FAILS,0,1,0,1,0)); end
        tick();
        send(8'h90);
        idle(254);
        send(8'hA4);
        total++; if (obs() !== ev(MATCH,0,0,0,1,2)) begin bad++; $display("FAIL to_edge got=%h exp=%h", obs(), ev(MATCH,0,0,0,1,2)); end
        send(8'h82); send(8'hC7);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL to_grant got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
    endtask

    task automatic test_reset_mid();
        send(8'h90); send(8'hA4);
        total++; if (obs() !== ev(MATCH,0,0,0,0,2)) begin bad++; $display("FAIL rst_pre got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,2)); end
        res = 1'b1; valid = 1'b1; entrada = 8'h82;
        prog_we = 1'b1; prog_addr = 2'd0; prog_data = 8'h55;
        tick();
        res = 1'b0; valid = 1'b0; prog_we = 1'b0;
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL rst_entry got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
        send(8'h00);
        total++; if (obs() !== ev(MATCH,0,0,0,0,1)) begin bad++; $display("FAIL rst_ref0 got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,1)); end
        send(8'h00); send(8'h00); send(8'h00);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL rst_zero_grant got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
        for (int i = 0; i < 3; i++) begin send(8'h55); tick(); end
        total++; if (obs() !== ev(LOCK,0,0,1,3,0)) begin bad++; $display("FAIL rst_lock got=%h exp=%h", obs(), ev(LOCK,0,0,1,3,0)); end
        idle(100);
        res = 1'b1;
        tick();
        res = 1'b0;
        total++; if (obs() !== ev(IDLE,0,0,0,0,0)) begin bad++; $display("FAIL rst_in_lock got=%h exp=%h", obs(), ev(IDLE,0,0,0,0,0)); end
        for (int i = 0; i < 4; i++) send(8'h00);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL rst_lock_grant got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
    endtask

    task automatic test_prog();
        for (int i = 0; i < 4; i++) prog(2'(i), seq[i]);
        send(8'h90);
        prog(2'd1, 8'h11);
        send(8'hA4);
        total++; if (obs() !== ev(MATCH,0,0,0,0,2)) begin bad++; $display("FAIL prog_in_match got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,2)); end
        send(8'h82); send(8'hC7);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL prog_grant1 got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
        prog_we = 1'b1; prog_addr = 2'd0; prog_data = 8'h33;
        valid = 1'b1; entrada = 8'h90;
        tick();
        prog_we = 1'b0; valid = 1'b0;
        total++; if (obs() !== ev(MATCH,0,0,0,0,1)) begin bad++; $display("FAIL prog_old_cmp got=%h exp=%h", obs(), ev(MATCH,0,0,0,0,1)); end
        send(8'hA4); send(8'h82); send(8'hC7);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL prog_grant2 got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
        send(8'h90);
        total++; if (obs() !== ev(FAILS,0,1,0,1,0)) begin bad++; $display("FAIL prog_old_rej got=%h exp=%h", obs(), ev(FAILS,0,1,0,1,0)); end
        tick();
        send(8'h33);
        total++; if (obs() !== ev(MATCH,0,0,0,1,1)) begin bad++; $display("FAIL prog_new_acc got=%h exp=%h", obs(), ev(MATCH,0,0,0,1,1)); end
        send(8'hA4); send(8'h82); send(8'hC7);
        total++; if (obs() !== ev(GRANT,1,0,0,0,0)) begin bad++; $display("FAIL prog_grant3 got=%h exp=%h", obs(), ev(GRANT,1,0,0,0,0)); end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seq_grant();
        test_back_to_back();
        test_wrong_code();
        test_lockout();
        test_timeout();
        test_reset_mid();
        test_prog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
